// File: rtl/id_ex_operand_stage.sv
// ID-side operand stage: drives register-file read addresses, resolves operands and fills the ID/EX register.
// Optional same-cycle WB bypass into the operands is enabled by defining IDEX_WB_BYPASS_EN.
module id_ex_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_id_i,
  input  logic [31:0]       instr_id_i,
  input  logic [XLEN-1:0]   pc_id_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              rd_write_en_wb_i,
  input  logic [REG_AW-1:0] rd_addr_wb_i,
  input  logic [XLEN-1:0]   rd_data_wb_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              stall_id_o,
  output logic              valid_ex_o,
  output logic [XLEN-1:0]   pc_ex_o,
  output logic [31:0]       instr_ex_o,
  output logic [XLEN-1:0]   rs1_data_ex_o,
  output logic [XLEN-1:0]   rs2_data_ex_o,
  output logic [REG_AW-1:0] rs1_addr_ex_o,
  output logic [REG_AW-1:0] rs2_addr_ex_o,
  output logic [REG_AW-1:0] rd_addr_ex_o
);

  localparam int unsigned ILEN = 32;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [ILEN-1:0]   instr_q,    instr_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;

  logic [6:0]        opcode;
  logic              use_rs1, use_rs2, load_use;
  logic [XLEN-1:0]   rs1_src, rs2_src, rs1_op, rs2_op;

  assign rs1_addr_o = REG_AW'(instr_id_i[19:15]);
  assign rs2_addr_o = REG_AW'(instr_id_i[24:20]);
  assign opcode     = instr_id_i[6:0];

  assign use_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

  // A load in EX whose result the ID instruction actually consumes
  assign load_use = valid_id_i && valid_q && (instr_q[6:0] == OPC_LOAD) && (rd_addr_q != '0) &&
                    ((use_rs1 && (rd_addr_q == rs1_addr_o)) || (use_rs2 && (rd_addr_q == rs2_addr_o)));

  assign stall_id_o = !flush_i && (hold_i || load_use);

`ifdef IDEX_WB_BYPASS_EN
  assign rs1_src = (rd_write_en_wb_i && (rd_addr_wb_i != '0) && (rd_addr_wb_i == rs1_addr_o))
                   ? rd_data_wb_i : rs1_data_i;
  assign rs2_src = (rd_write_en_wb_i && (rd_addr_wb_i != '0) && (rd_addr_wb_i == rs2_addr_o))
                   ? rd_data_wb_i : rs2_data_i;
`else
  logic unused_wb;
  assign unused_wb = ^{rd_write_en_wb_i, rd_addr_wb_i, rd_data_wb_i};
  assign rs1_src   = rs1_data_i;
  assign rs2_src   = rs2_data_i;
`endif

  // x0 always reads as zero whatever the register file returns
  assign rs1_op = (rs1_addr_o == '0) ? '0 : rs1_src;
  assign rs2_op = (rs2_addr_o == '0) ? '0 : rs2_src;

  // Next-state: flush > hold > load-use bubble > capture
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!hold_i) begin
      if (load_use) begin
        valid_d = 1'b0;
      end else begin
        valid_d    = valid_id_i;
        pc_d       = pc_id_i;
        instr_d    = instr_id_i;
        rs1_data_d = rs1_op;
        rs2_data_d = rs2_op;
        rs1_addr_d = rs1_addr_o;
        rs2_addr_d = rs2_addr_o;
        rd_addr_d  = REG_AW'(instr_id_i[11:7]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign valid_ex_o    = valid_q;
  assign pc_ex_o       = pc_q;
  assign instr_ex_o    = instr_q;
  assign rs1_data_ex_o = rs1_data_q;
  assign rs2_data_ex_o = rs2_data_q;
  assign rs1_addr_ex_o = rs1_addr_q;
  assign rs2_addr_ex_o = rs2_addr_q;
  assign rd_addr_ex_o  = rd_addr_q;

endmodule
